// File: rtl/apb_pkg.sv
// Shared APB definitions for the master and completers on the fabric.
// FSM states, default bus widths and strobe width derivation.
package apb_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  localparam int APB_AW = 8;
  localparam int APB_DW = 32;

  function automatic int apb_strb_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/apb_regfile_mem.sv
// Byte-writable flop array with one write port and one combinational read.
// Cleared to zero by synchronous reset.
module apb_regfile_mem
  import apb_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = APB_DW,
  parameter int IW         = APB_AW - 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [IW-1:0]           waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [IW-1:0]           raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int SW = apb_strb_w(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (we && waddr == IW'(i)) begin
        for (int b = 0; b < SW; b++) begin
          if (wstrb[b]) begin
            mem_d[i][b*8 +: 8] = wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == IW'(i)) begin
        rdata = mem_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer: captures each setup phase, waits WAIT_STATES cycles,
// then completes with PREADY, PRDATA and PSLVERR over a register array.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_AW,
  parameter int DATA_WIDTH  = APB_DW,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam int SW = apb_strb_w(DATA_WIDTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [IW:0] DEPTH_W = (IW + 1)'(DEPTH);

  apb_state_e state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         strb_q, strb_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  acc_wr;
  logic                  acc_err;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  mem_we;

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a[ADDR_WIDTH-1:2]} >= DEPTH_W);
  endfunction

  // Zero-wait completions respond straight from the setup-phase bus.
  always_comb begin
    acc_addr  = (state_q == IDLE) ? PADDR : addr_q;
    acc_wr    = (state_q == IDLE) ? PWRITE : wr_q;
    acc_err   = addr_err(acc_addr);
    resp_data = (acc_err || acc_wr) ? '0 : mem_rdata;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    ready_d = ready_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          wr_d    = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          cnt_d   = WS;
          state_d = ACCESS;
          if (WS == 4'd0) begin
            ready_d = 1'b1;
            err_d   = acc_err;
            rdata_d = resp_data;
          end
        end
      end
      ACCESS: begin
        if (!PSEL || ready_q) begin
          mem_we  = PSEL && wr_q && !err_q;
          state_d = IDLE;
          cnt_d   = '0;
          ready_d = 1'b0;
          err_d   = 1'b0;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            ready_d = 1'b1;
            err_d   = acc_err;
            rdata_d = resp_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  apb_regfile_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IW         (IW)
  ) u_mem (
    .clk   (PCLK),
    .rst   (PRESET),
    .we    (mem_we),
    .waddr (addr_q[ADDR_WIDTH-1:2]),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .raddr (acc_addr[ADDR_WIDTH-1:2]),
    .rdata (mem_rdata)
  );

  assign PREADY  = ready_q;
  assign PSLVERR = err_q;
  assign PRDATA  = rdata_q;

endmodule
